riscv_lsu_ctrl: RTL

Load/store controller between the core datapath and the data-memory port. It takes the decoder's memory controls (mem_req, mem_we, mem_size) together with the ALU address and the rs2 data. It runs a multi-cycle request/ready handshake to memory and generates byte enables and write-data replication. Load data is returned aligned and sign/zero-extended, and the core is stalled until the access completes or faults.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/lsu_data_align.sv | 40 ++++
 rtl/riscv_lsu_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: memory access sizes and load/store unit types.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} lsu_state_t;
  typedef enum logic [1:0] {FLT_NONE, FLT_LMIS, FLT_SMIS, FLT_ACC} lsu_fault_e;

  function automatic logic lsu_size_legal(input logic [2:0] size);
    return size inside {LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU};
  endfunction

  // Unsigned variants share the alignment rule of their signed counterparts.
  function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size[1:0])
      2'd1:    return addr_lo[0];
      2'd2:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-enable / store-data replication and load-data extraction with extension.
module lsu_data_align
  import riscv_pkg::*;
(
  input  logic [2:0]      i_size,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wd,
  input  logic [XLEN-1:0] i_rd,
  output logic [3:0]      o_be_c,
  output logic [XLEN-1:0] o_wd_c,
  output logic [XLEN-1:0] o_rd_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_rd >> {i_addr_lo, 3'b000});
  assign w_half = i_addr_lo[1] ? i_rd[31:16] : i_rd[15:0];

  // size[2] selects zero extension; it is ignored for byte lanes and store data.
  always_comb begin
    o_be_c = 4'b1111;
    o_wd_c = i_wd;
    o_rd_c = i_rd;
    case (i_size[1:0])
      2'd0: begin
        o_be_c = 4'b0001 << i_addr_lo;
        o_wd_c = {4{i_wd[7:0]}};
        o_rd_c = i_size[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'd1: begin
        o_be_c = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wd_c = {2{i_wd[15:0]}};
        o_rd_c = i_size[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Load/store controller: request/ready handshake to data memory with timeout,
// alignment checks, and formatted load return; stalls the core while busy.
module riscv_lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        load_misalign_o,
  output logic        store_misalign_o,
  output logic        access_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t       r_state, w_state_nxt;
  lsu_fault_e       r_fault, w_fault_nxt;
  logic             w_capture;
  logic             r_we;
  logic [2:0]       r_size;
  logic [31:0]      r_addr, r_wd, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_in_req, w_timeout;
  logic [3:0]       w_be;
  logic [31:0]      w_wd, w_ld;

  assign w_in_req  = r_state == REQ;
  assign w_timeout = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_fault <= FLT_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fault_nxt = r_fault;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (core_req_i) begin
          if (!lsu_size_legal(core_size_i)) begin
            w_state_nxt = FAULT;
            w_fault_nxt = FLT_ACC;
          end else if (lsu_misaligned(core_size_i, core_addr_i[1:0])) begin
            w_state_nxt = FAULT;
            w_fault_nxt = core_we_i ? FLT_SMIS : FLT_LMIS;
          end else begin
            w_state_nxt = REQ;
            w_capture   = 1'b1;
          end
        end
      end
      // A ready arriving on the final timeout cycle still completes the access.
      REQ: begin
        if (mem_ready_i) begin
          w_state_nxt = DONE;
        end else if (w_timeout) begin
          w_state_nxt = FAULT;
          w_fault_nxt = FLT_ACC;
        end
      end
      DONE:    w_state_nxt = IDLE;
      FAULT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_we   <= 1'b0;
      r_size <= '0;
      r_addr <= '0;
      r_wd   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_capture) begin
        r_we   <= core_we_i;
        r_size <= core_size_i;
        r_addr <= core_addr_i;
        r_wd   <= core_wd_i;
        r_cnt  <= '0;
      end else if (w_in_req && !mem_ready_i && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_in_req && mem_ready_i) begin
        r_rd <= r_we ? 32'b0 : w_ld;
      end
    end
  end

  lsu_data_align u_align (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .i_wd      (r_wd),
    .i_rd      (mem_rd_i),
    .o_be_c    (w_be),
    .o_wd_c    (w_wd),
    .o_rd_c    (w_ld)
  );

  assign core_stall_o     = core_req_i & ((r_state == IDLE) | (r_state == REQ));
  assign core_rd_o        = r_rd;
  assign mem_req_o        = w_in_req;
  assign mem_we_o         = w_in_req & r_we;
  assign mem_be_o         = w_in_req ? w_be : 4'b0;
  assign mem_addr_o       = w_in_req ? {r_addr[31:2], 2'b00} : 32'b0;
  assign mem_wd_o         = w_in_req ? w_wd : 32'b0;
  assign load_misalign_o  = (r_state == FAULT) & (r_fault == FLT_LMIS);
  assign store_misalign_o = (r_state == FAULT) & (r_fault == FLT_SMIS);
  assign access_fault_o   = (r_state == FAULT) & (r_fault == FLT_ACC);

endmodule
